// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: serialises CPU and debug/loader accesses onto the
// single unified memory, round-robin when both ports request together.
module mem_port_arbiter #(
  parameter int DW      = 32,
  parameter int AW      = 32,
  parameter int MEM_LAT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_ack,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_stall,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  output logic          dbg_ack,
  output logic [DW-1:0] dbg_rdata,
  output logic          mem_rd,
  output logic          mem_wr,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  if (MEM_LAT < 1) begin : g_lat_chk
    $error("mem_port_arbiter: MEM_LAT must be >= 1");
  end

  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(MEM_LAT - 1);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;
  logic          last_dbg;
  logic          we_l;
  logic          pick_dbg;
  logic          any_req;

  assign any_req = cpu_req | dbg_req;

  // last_dbg doubles as the current grantee once an access starts
  always_comb begin
    pick_dbg = 1'b0;
    unique case (1'b1)
      cpu_req & dbg_req:  pick_dbg = ~last_dbg;
      dbg_req & ~cpu_req: pick_dbg = 1'b1;
      default:            pick_dbg = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (any_req) state_nxt = ACCESS;
      ACCESS:  if (cnt == '0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign mem_rd    = (state == ACCESS) & ~we_l;
  assign mem_wr    = (state == ACCESS) &  we_l;
  assign cpu_ack   = (state == DONE) & ~last_dbg;
  assign dbg_ack   = (state == DONE) &  last_dbg;
  assign cpu_stall = cpu_req & ~cpu_ack;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      last_dbg  <= 1'b1;
      we_l      <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_rdata <= '0;
      dbg_rdata <= '0;
    end else begin
      state <= state_nxt;
      unique case (state)
        IDLE: begin
          if (any_req) begin
            last_dbg  <= pick_dbg;
            cnt       <= CNT_INIT;
            we_l      <= pick_dbg ? dbg_we    : cpu_we;
            mem_addr  <= pick_dbg ? dbg_addr  : cpu_addr;
            mem_wdata <= pick_dbg ? dbg_wdata : cpu_wdata;
          end
        end
        ACCESS: begin
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else if (!we_l) begin
            if (last_dbg) dbg_rdata <= mem_rdata;
            else          cpu_rdata <= mem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
